// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - constants shared by the control unit and the interrupt controller
package cpu_defs;

    localparam int ADDR_WIDTH    = 16;
    localparam int N_IRQ         = 4;
    localparam int VECTOR_STRIDE = 2;

    typedef logic [ADDR_WIDTH-1:0] addr_t;

    localparam addr_t VECTOR_BASE = 16'h0010;

    // Control ext code that retires the current in-service interrupt.
    localparam logic [3:0] CLRI = 4'b1111;

endpackage

// File: rtl/irq_edge_sync.sv
// rtl/irq_edge_sync.sv - two-flop synchroniser and rising-edge detector for one interrupt line
module irq_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic irq_i,
    output logic rise_o
);

    logic       s0_q;
    logic       s1_q;
    logic       prev_q;
    logic [2:0] fill_q;

    // Free-running synchroniser, one-sample history and a warm-up shift that
    // marks when prev_q holds a real sample of the line rather than reset zeros.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0_q   <= 1'b0;
            s1_q   <= 1'b0;
            prev_q <= 1'b0;
            fill_q <= 3'b000;
        end else begin
            s0_q   <= irq_i;
            s1_q   <= s0_q;
            prev_q <= s1_q;
            fill_q <= {fill_q[1:0], 1'b1};
        end
    end

    // A line held high across reset must not look like a fresh edge, so the
    // detector stays quiet until both compared samples came from the pin.
    assign rise_o = s1_q & ~prev_q & fill_q[2];

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - edge-latched, masked, fixed-priority nesting interrupt controller
module interrupt_controller #(
    parameter int                    N_IRQ         = cpu_defs::N_IRQ,
    parameter int                    ADDR_WIDTH    = cpu_defs::ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] VECTOR_BASE   = ADDR_WIDTH'(cpu_defs::VECTOR_BASE),
    parameter int                    VECTOR_STRIDE = cpu_defs::VECTOR_STRIDE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [N_IRQ-1:0]      irq,
    input  logic                  mask_wr_en,
    input  logic [N_IRQ-1:0]      mask_in,
    input  logic                  request_interrupt,
    input  logic                  vector_to_pc,
    input  logic                  clear_interrupt,
    output logic                  interrupt,
    output logic [ADDR_WIDTH-1:0] vector,
    output logic [N_IRQ-1:0]      pending,
    output logic [N_IRQ-1:0]      in_service,
    output logic [N_IRQ-1:0]      mask
);

    localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    logic [N_IRQ-1:0]      rise;
    logic [N_IRQ-1:0]      pending_q, pending_d;
    logic [N_IRQ-1:0]      in_service_q, in_service_d;
    logic [N_IRQ-1:0]      mask_q;
    logic [N_IRQ-1:0]      clr_onehot;
    logic [IDX_W-1:0]      sel_q, sel_d;
    logic [IDX_W-1:0]      cand;
    logic                  cand_found;
    logic                  cand_blocked;
    logic                  cand_valid;
    logic                  take;
    logic [ADDR_WIDTH-1:0] vector_q, vector_d;

    for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
        irq_edge_sync u_sync (
            .clk    (clk),
            .reset  (reset),
            .irq_i  (irq[g]),
            .rise_o (rise[g])
        );
    end

    // Lowest enabled pending index wins; it is blocked by any in-service
    // source of equal or higher priority, so only strictly higher ones nest.
    always_comb begin
        cand         = '0;
        cand_found   = 1'b0;
        cand_blocked = 1'b0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (pending_q[i] && mask_q[i]) begin
                cand       = IDX_W'(i);
                cand_found = 1'b1;
            end
        end
        for (int i = 0; i < N_IRQ; i++) begin
            if (in_service_q[i] && (IDX_W'(i) <= cand)) begin
                cand_blocked = 1'b1;
            end
        end
    end

    assign cand_valid = cand_found & ~cand_blocked;
    assign interrupt  = request_interrupt & cand_valid;
    assign take       = en & request_interrupt & cand_valid;
    assign clr_onehot = in_service_q & (~in_service_q + N_IRQ'(1));

    // Next state: select, then clear on the old in-service set, then
    // acknowledge; a new edge always re-arms pending last.
    always_comb begin
        pending_d    = pending_q;
        in_service_d = in_service_q;
        sel_d        = sel_q;
        vector_d     = vector_q;
        if (take) begin
            sel_d    = cand;
            vector_d = VECTOR_BASE + ADDR_WIDTH'(cand) * ADDR_WIDTH'(VECTOR_STRIDE);
        end
        if (en && clear_interrupt) begin
            in_service_d = in_service_q & ~clr_onehot;
        end
        if (en && vector_to_pc) begin
            for (int i = 0; i < N_IRQ; i++) begin
                if (sel_q == IDX_W'(i)) begin
                    pending_d[i]    = 1'b0;
                    in_service_d[i] = 1'b1;
                end
            end
        end
        pending_d = pending_d | rise;
    end

    // Handshake state and the vector latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q    <= '0;
            in_service_q <= '0;
            sel_q        <= '0;
            vector_q     <= VECTOR_BASE;
        end else begin
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            sel_q        <= sel_d;
            vector_q     <= vector_d;
        end
    end

    // Mask register is written independently of the step enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
        end else if (mask_wr_en) begin
            mask_q <= mask_in;
        end
    end

    assign vector     = vector_q;
    assign pending    = pending_q;
    assign in_service = in_service_q;
    assign mask       = mask_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - self-checking bench for interrupt_controller
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  irq;
    logic        mask_wr_en;
    logic [3:0]  mask_in;
    logic        request_interrupt;
    logic        vector_to_pc;
    logic        clear_interrupt;
    logic        interrupt;
    logic [15:0] vector;
    logic [3:0]  pending;
    logic [3:0]  in_service;
    logic [3:0]  mask;

    always #5 clk = ~clk;

    interrupt_controller dut (
        .clk               (clk),
        .reset             (reset),
        .en                (en),
        .irq               (irq),
        .mask_wr_en        (mask_wr_en),
        .mask_in           (mask_in),
        .request_interrupt (request_interrupt),
        .vector_to_pc      (vector_to_pc),
        .clear_interrupt   (clear_interrupt),
        .interrupt         (interrupt),
        .vector            (vector),
        .pending           (pending),
        .in_service        (in_service),
        .mask              (mask)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state.
    logic [3:0]  m_pend, m_isr, m_mask;
    logic [3:0]  samp0, samp1, samp2;
    logic [15:0] m_vec;
    int          m_sel;
    int          m_cnt;

    typedef struct {
        logic [3:0]  irq;
        logic        mwr;
        logic [3:0]  min;
        logic        req, ack, clr;
        logic [3:0]  pend, isr;
        logic        intr;
        logic [15:0] vec;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [3:0] i, input logic w, input logic [3:0] mi,
                                input logic rq, input logic ak, input logic cl,
                                input logic [3:0] p, input logic [3:0] s,
                                input logic it, input logic [15:0] v);
        vec_t r;
        r.irq = i; r.mwr = w; r.min = mi; r.req = rq; r.ack = ak; r.clr = cl;
        r.pend = p; r.isr = s; r.intr = it; r.vec = v;
        return r;
    endfunction

    function automatic int cand_of(input logic [3:0] p, input logic [3:0] mk_v);
        for (int i = 0; i < 4; i++) if (p[i] && mk_v[i]) return i;
        return -1;
    endfunction

    function automatic int lowest_set(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 4;
    endfunction

    function automatic bit cand_ok(input logic [3:0] p, input logic [3:0] mk_v, input logic [3:0] s);
        int c;
        c = cand_of(p, mk_v);
        return (c >= 0) && (c < lowest_set(s));
    endfunction

    task automatic model_reset();
        m_pend = '0; m_isr = '0; m_mask = '0;
        samp0 = '0; samp1 = '0; samp2 = '0;
        m_vec = 16'h0010; m_sel = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        logic [3:0] rise_v, np, ni;
        int c, old_sel;
        if (reset) begin
            model_reset();
            return;
        end
        rise_v  = (m_cnt >= 3) ? (samp1 & ~samp2) : 4'b0000;
        c       = cand_of(m_pend, m_mask);
        old_sel = m_sel;
        np      = m_pend;
        ni      = m_isr;
        if (en && request_interrupt && cand_ok(m_pend, m_mask, m_isr)) begin
            m_sel = c;
            m_vec = 16'(32'h0010 + c * 2);
        end
        if (en && clear_interrupt && (m_isr != 4'b0000)) ni[lowest_set(m_isr)] = 1'b0;
        if (en && vector_to_pc) begin
            np[old_sel] = 1'b0;
            ni[old_sel] = 1'b1;
        end
        m_pend = np | rise_v;
        m_isr  = ni;
        if (mask_wr_en) m_mask = mask_in;
        samp2 = samp1; samp1 = samp0; samp0 = irq;
        if (m_cnt < 3) m_cnt++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        check("model.interrupt", 32'(interrupt), 32'(request_interrupt && cand_ok(m_pend, m_mask, m_isr)));
        check("model.vector", 32'(vector), 32'(m_vec));
        check("model.pending", 32'(pending), 32'(m_pend));
        check("model.in_service", 32'(in_service), 32'(m_isr));
        check("model.mask", 32'(mask), 32'(m_mask));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic idle_inputs();
        mask_wr_en = 0; mask_in = '0; request_interrupt = 0;
        vector_to_pc = 0; clear_interrupt = 0;
    endtask

    task automatic sync_reset_pulse();
        reset = 1;
        model_reset();
        tick();
        reset = 0;
    endtask

    initial begin
        reset = 1; en = 1; irq = '0;
        idle_inputs();
        model_reset();
        tick();
        check("reset.pending", 32'(pending), 32'h0);
        check("reset.in_service", 32'(in_service), 32'h0);
        check("reset.mask", 32'(mask), 32'h0);
        check("reset.vector", 32'(vector), 32'h0010);
        check("reset.interrupt", 32'(interrupt), 32'h0);
        reset = 0;

        //          irq     w  min     rq ak cl  pend    isr     int vec
        tbl.push_back(mk(4'b0000, 1, 4'b0010, 0, 0, 0, 4'b0000, 4'b0000, 0, 16'h0010));
        tbl.push_back(mk(4'b0010, 0, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 0, 16'h0010));
        tbl.push_back(mk(4'b0010, 0, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 0, 16'h0010));
        tbl.push_back(mk(4'b0010, 0, 4'b0000, 1, 0, 0, 4'b0010, 4'b0000, 1, 16'h0010));
        tbl.push_back(mk(4'b0010, 0, 4'b0000, 1, 0, 0, 4'b0010, 4'b0000, 1, 16'h0012));
        tbl.push_back(mk(4'b0010, 0, 4'b0000, 0, 1, 0, 4'b0000, 4'b0010, 0, 16'h0012));
        tbl.push_back(mk(4'b0010, 0, 4'b0000, 0, 0, 1, 4'b0000, 4'b0000, 0, 16'h0012));
        tbl.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 16'h0012));
        tbl.push_back(mk(4'b1010, 1, 4'b1111, 0, 0, 0, 4'b0000, 4'b0000, 0, 16'h0012));
        tbl.push_back(mk(4'b1010, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 16'h0012));
        tbl.push_back(mk(4'b1010, 0, 4'b0000, 1, 0, 0, 4'b1010, 4'b0000, 1, 16'h0012));
        tbl.push_back(mk(4'b1010, 0, 4'b0000, 1, 0, 0, 4'b1010, 4'b0000, 1, 16'h0012));
        tbl.push_back(mk(4'b1010, 0, 4'b0000, 0, 1, 0, 4'b1000, 4'b0010, 0, 16'h0012));
        tbl.push_back(mk(4'b1010, 0, 4'b0000, 1, 0, 0, 4'b1000, 4'b0010, 0, 16'h0012));
        tbl.push_back(mk(4'b1010, 0, 4'b0000, 0, 0, 1, 4'b1000, 4'b0000, 0, 16'h0012));
        tbl.push_back(mk(4'b1010, 0, 4'b0000, 1, 0, 0, 4'b1000, 4'b0000, 1, 16'h0016));
        tbl.push_back(mk(4'b1010, 0, 4'b0000, 0, 1, 0, 4'b0000, 4'b1000, 0, 16'h0016));
        tbl.push_back(mk(4'b1001, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b1000, 0, 16'h0016));
        tbl.push_back(mk(4'b1001, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b1000, 0, 16'h0016));
        tbl.push_back(mk(4'b1001, 0, 4'b0000, 1, 0, 0, 4'b0001, 4'b1000, 1, 16'h0016));
        tbl.push_back(mk(4'b1001, 0, 4'b0000, 1, 0, 0, 4'b0001, 4'b1000, 1, 16'h0010));
        tbl.push_back(mk(4'b1001, 0, 4'b0000, 0, 1, 0, 4'b0000, 4'b1001, 0, 16'h0010));
        tbl.push_back(mk(4'b1101, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b1001, 0, 16'h0010));
        tbl.push_back(mk(4'b1101, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b1001, 0, 16'h0010));
        tbl.push_back(mk(4'b1101, 0, 4'b0000, 1, 0, 0, 4'b0100, 4'b1001, 0, 16'h0010));
        tbl.push_back(mk(4'b1101, 0, 4'b0000, 0, 0, 1, 4'b0100, 4'b1000, 0, 16'h0010));
        tbl.push_back(mk(4'b1101, 0, 4'b0000, 1, 0, 0, 4'b0100, 4'b1000, 1, 16'h0014));
        tbl.push_back(mk(4'b1101, 0, 4'b0000, 0, 1, 0, 4'b0000, 4'b1100, 0, 16'h0014));
        tbl.push_back(mk(4'b1101, 0, 4'b0000, 0, 0, 1, 4'b0000, 4'b1000, 0, 16'h0014));
        tbl.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 1, 4'b0000, 4'b0000, 0, 16'h0014));
        tbl.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 1, 4'b0000, 4'b0000, 0, 16'h0014));

        foreach (tbl[r]) begin
            irq = tbl[r].irq; mask_wr_en = tbl[r].mwr; mask_in = tbl[r].min;
            request_interrupt = tbl[r].req; vector_to_pc = tbl[r].ack; clear_interrupt = tbl[r].clr;
            tick();
            check($sformatf("tbl[%0d].pending", r), 32'(pending), 32'(tbl[r].pend));
            check($sformatf("tbl[%0d].in_service", r), 32'(in_service), 32'(tbl[r].isr));
            check($sformatf("tbl[%0d].interrupt", r), 32'(interrupt), 32'(tbl[r].intr));
            check($sformatf("tbl[%0d].vector", r), 32'(vector), 32'(tbl[r].vec));
        end
        idle_inputs();

        // New edge on source 1 lands in the same cycle as its acknowledge.
        irq = 4'b0010; tick();
        irq = 4'b0000; tick();
        irq = 4'b0010; tick();
        request_interrupt = 1; tick();
        check("same.vector", 32'(vector), 32'h0012);
        request_interrupt = 0; vector_to_pc = 1; tick();
        vector_to_pc = 0;
        check("same.pending1", 32'(pending[1]), 32'h1);
        check("same.in_service1", 32'(in_service[1]), 32'h1);

        // Masked pending stays pending and fires once unmasked.
        sync_reset_pulse();
        irq = 4'b0000; tick(); tick();
        irq = 4'b0100; request_interrupt = 1;
        repeat (4) tick();
        check("mask0.pending", 32'(pending), 32'h4);
        check("mask0.interrupt", 32'(interrupt), 32'h0);
        request_interrupt = 0; mask_wr_en = 1; mask_in = 4'b0101; tick();
        mask_wr_en = 0; request_interrupt = 1; #1;
        check("unmask.interrupt", 32'(interrupt), 32'h1);

        // Build in_service=0001 and pending=0100, then reset asynchronously with en low.
        request_interrupt = 0;
        irq = 4'b0101; repeat (3) tick();
        request_interrupt = 1; tick();
        check("pre_rst.vector", 32'(vector), 32'h0010);
        request_interrupt = 0; vector_to_pc = 1; tick();
        vector_to_pc = 0; en = 0; tick();
        check("pre_rst.pending", 32'(pending), 32'h4);
        check("pre_rst.in_service", 32'(in_service), 32'h1);
        #2;
        reset = 1;
        model_reset();
        #1;
        check("async_rst.pending", 32'(pending), 32'h0);
        check("async_rst.in_service", 32'(in_service), 32'h0);
        check("async_rst.mask", 32'(mask), 32'h0);
        check("async_rst.vector", 32'(vector), 32'h0010);
        check("async_rst.interrupt", 32'(interrupt), 32'h0);
        tick();
        reset = 0; en = 1;
        mask_wr_en = 1; mask_in = 4'b1111; tick();
        mask_wr_en = 0;
        repeat (6) tick();
        check("no_retrigger.pending", 32'(pending), 32'h0);
        clear_interrupt = 1; tick();
        clear_interrupt = 0;
        check("clr_empty.in_service", 32'(in_service), 32'h0);
        check("clr_empty.pending", 32'(pending), 32'h0);

        // Randomised traffic against the reference model.
        irq = '0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                idle_inputs();
                sync_reset_pulse();
            end
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) irq[b] = ~irq[b];
            en                = ($urandom_range(0, 7) != 0);
            request_interrupt = $urandom_range(0, 1) == 1;
            vector_to_pc      = ($urandom_range(0, 3) == 0);
            clear_interrupt   = ($urandom_range(0, 4) == 0);
            mask_wr_en        = ($urandom_range(0, 15) == 0);
            mask_in           = 4'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
